float_wb_scheduler: RTL and testbench
=====================================

FLOAT_WB_SCHEDULER -- requirements
Module: float_wb_scheduler

Interface
REQ-001 SHALL have parameter FPU_FIRST, default 1, meaning FPU holds priority after reset when 1; load holds priority when 0.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-004 SHALL have ports issue_valid input 1, issue_rd input 5, issue_rs1 input 5, issue_rs2 input 5, describing the decode-stage float instruction.
REQ-005 SHALL have port stall  output  1  combinational; decode SHALL hold when 1.
REQ-006 SHALL have ports fpu_valid input 1, fpu_rd input 5, fpu_data input 32, fpu_ready output 1, for the FPU result channel.
REQ-007 SHALL have ports ld_valid input 1, ld_rd input 5, ld_data input 32, ld_ready output 1, for the FLW load-return channel.
REQ-008 SHALL have ports float_wb_en output 1, float_wb_addr output 5, float_write_data output 32, all registered, driving the float register file write port.
REQ-009 SHALL have port wb_err  output  1  sticky flag: completion to a non-busy register.

Function
REQ-010 SHALL keep a 32-bit busy scoreboard; bit 0 SHALL always read 0.
REQ-011 stall SHALL be 1 when issue_valid=1 and any of busy[issue_rs1], busy[issue_rs2] or busy[issue_rd] (WAW) is 1; else 0.
REQ-012 issue_fire = issue_valid & ~stall; on issue_fire with issue_rd!=0, busy[issue_rd] SHALL set at the next edge.
REQ-013 Channel handshake: a transfer occurs when valid & ready are both 1; ready is combinational from valids and the priority pointer only.
REQ-014 SHALL grant at most one channel per cycle; a sole valid channel SHALL be granted in the same cycle.
REQ-015 When both are valid, SHALL grant the channel named by the priority pointer, then move the pointer to the other channel; the pointer SHALL change only on a contested grant.
REQ-016 A channel with valid=1 and ready=0 SHALL hold rd/data stable; this block SHALL neither drop nor reorder requests.
REQ-017 A transfer in cycle N SHALL set float_wb_en=1 with the granted rd/data in cycle N+1; no transfer in cycle N SHALL set float_wb_en=0 in N+1.
REQ-018 A transfer with rd=0 SHALL be accepted and produce float_wb_en=0; it SHALL NOT set wb_err.
REQ-019 busy[addr] SHALL clear at the edge ending the cycle where float_wb_en=1 with that address, i.e. together with the register file write.
REQ-020 If a set (REQ-012) and a clear (REQ-019) target the same bit on the same edge, set SHALL win.
REQ-021 A transfer whose rd!=0 and busy[rd]=0 SHALL still be written and SHALL set wb_err=1 until reset.
REQ-022 Sustained throughput SHALL be one write per cycle; there is no back-pressure from the write port.

Reset
REQ-023 On rst: busy=0, float_wb_en=0, float_wb_addr=0, float_write_data=0, wb_err=0, pointer=FPU if FPU_FIRST=1 else load.
REQ-024 Reset mid-operation SHALL discard the pending output write and all busy state; a handshake in the reset cycle is lost.
REQ-025 During reset, stall SHALL be 0 and readies SHALL follow REQ-014/015 using the reset pointer.

Verification
REQ-026 Issue rd=5 -> next cycle issue rs1=5: stall=1 until FPU returns rd=5 data 0x3F800000; wb_en/addr=5/data in the following cycle; stall=0 one cycle later.
REQ-027 fpu_valid and ld_valid both high for 4 cycles (FPU_FIRST=1): grants FPU, LD, FPU, LD; wb_addr sequence follows; each channel's data is held while not ready.
REQ-028 Load completion with rd=0 and data 0xFFFFFFFF: ld_ready=1, float_wb_en=0 next cycle, wb_err=0.
REQ-029 FPU completion to rd=9 with busy[9]=0: write of rd=9 occurs; wb_err=1 and stays 1 until rst.
REQ-030 Issue rd=7 in the same cycle that wb_en=1 with addr=7 (after a prior clear): busy[7]=1 afterward (set wins); a later issue rs2=7 stalls.
REQ-031 Assert rst while wb_en=1 and busy[3]=1: outputs 0 immediately, busy[3]=0 after release, an issue with rs1=3 does not stall.

Source files
------------

// File: rtl/float_wb_scheduler.sv
// Float register-file writeback scheduler: busy scoreboard for decode hazards plus
// a two-channel (FPU / load-return) round-robin arbiter feeding one registered write port.
module float_wb_scheduler #(
   parameter int FPU_FIRST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  issue_rs1,
   input  logic [4:0]  issue_rs2,
   output logic        stall,
   input  logic        fpu_valid,
   input  logic [4:0]  fpu_rd,
   input  logic [31:0] fpu_data,
   output logic        fpu_ready,
   input  logic        ld_valid,
   input  logic [4:0]  ld_rd,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   output logic        float_wb_en,
   output logic [4:0]  float_wb_addr,
   output logic [31:0] float_write_data,
   output logic        wb_err
);

   localparam logic PTR_RST_LD = (FPU_FIRST == 0);

   logic [31:0] r_busy;
   logic        r_ptr_ld;
   logic        r_wb_en;
   logic [4:0]  r_wb_addr;
   logic [31:0] r_wb_data;
   logic        r_err;

   logic        w_stall;
   logic        w_fire;
   logic        w_contest;
   logic        w_fpu_gnt;
   logic        w_ld_gnt;
   logic        w_xfer;
   logic [4:0]  w_rd;
   logic [31:0] w_data;
   logic [31:0] w_set;
   logic [31:0] w_clr;
   logic [31:0] w_busy_nxt;

   // Busy bits are cleared asynchronously by rst, so stall is 0 during reset.
   assign w_stall = issue_valid &
                    (r_busy[issue_rs1] | r_busy[issue_rs2] | r_busy[issue_rd]);
   assign w_fire  = issue_valid & ~w_stall;

   assign w_contest = fpu_valid & ld_valid;
   assign w_fpu_gnt = fpu_valid & (~ld_valid | ~r_ptr_ld);
   assign w_ld_gnt  = ld_valid & (~fpu_valid | r_ptr_ld);
   assign w_xfer    = w_fpu_gnt | w_ld_gnt;
   assign w_rd      = w_fpu_gnt ? fpu_rd : ld_rd;
   assign w_data    = w_fpu_gnt ? fpu_data : ld_data;

   // Clear lands with the register-file write; a same-edge issue set overrides it.
   assign w_set      = (w_fire && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
   assign w_clr      = r_wb_en ? (32'd1 << r_wb_addr) : 32'd0;
   assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy    <= 32'd0;
         r_ptr_ld  <= PTR_RST_LD;
         r_wb_en   <= 1'b0;
         r_wb_addr <= 5'd0;
         r_wb_data <= 32'd0;
         r_err     <= 1'b0;
      end else begin
         r_busy  <= w_busy_nxt;
         r_wb_en <= w_xfer && (w_rd != 5'd0);
         if (w_xfer) begin
            r_wb_addr <= w_rd;
            r_wb_data <= w_data;
         end
         if (w_contest)
            r_ptr_ld <= ~r_ptr_ld;
         if (w_xfer && (w_rd != 5'd0) && !r_busy[w_rd])
            r_err <= 1'b1;
      end
   end

   assign stall            = w_stall;
   assign fpu_ready        = w_fpu_gnt;
   assign ld_ready         = w_ld_gnt;
   assign float_wb_en      = r_wb_en;
   assign float_wb_addr    = r_wb_addr;
   assign float_write_data = r_wb_data;
   assign wb_err           = r_err;

endmodule

// File: tb/tb_float_wb_scheduler.sv
// Directed scenarios followed by a randomized run checked against a cycle-level
// scoreboard/arbiter model of the writeback scheduler.
module tb_float_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2;
   logic        stall;
   logic        fpu_valid;
   logic [4:0]  fpu_rd;
   logic [31:0] fpu_data;
   logic        fpu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        float_wb_en;
   logic [4:0]  float_wb_addr;
   logic [31:0] float_write_data;
   logic        wb_err;

   int n_pass = 0;
   int n_tot  = 0;
   int n_fail = 0;

   float_wb_scheduler #(.FPU_FIRST(1)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
      .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .float_wb_en(float_wb_en), .float_wb_addr(float_wb_addr),
      .float_write_data(float_write_data), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
      fpu_valid = 1'b0; fpu_rd = 5'd0; fpu_data = 32'd0;
      ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      issue_valid = 1'b1; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
   endtask

   // reference model state
   bit          mb[32];
   bit          mptr_ld, merr, mwen;
   logic [4:0]  mwaddr;
   logic [31:0] mwdata;
   bit          fhold, lhold;
   bit          e_stall, e_fg, e_lg, xfer;
   logic [4:0]  g_rd;
   logic [31:0] g_data;

   initial begin
      idle();
      rst = 1'b1;
      #1;
      // reset state, readies follow reset pointer (FPU)
      fpu_valid = 1'b1; ld_valid = 1'b1; issue(5'd2, 5'd3, 5'd4);
      #1;
      chk("rst_wb_en", 32'(float_wb_en), 32'd0);
      chk("rst_wb_addr", 32'(float_wb_addr), 32'd0);
      chk("rst_wb_data", float_write_data, 32'd0);
      chk("rst_err", 32'(wb_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_fpu_ready", 32'(fpu_ready), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      tick(); tick();
      rst = 1'b0; idle();
      tick();
      chk("rst_lost_hs", 32'(float_wb_en), 32'd0);

      // RAW hazard on rd=5 resolved by FPU return
      issue(5'd5, 5'd1, 5'd2); #1;
      chk("raw_issue_stall", 32'(stall), 32'd0);
      tick();
      issue(5'd6, 5'd5, 5'd0); #1;
      chk("raw_stall_a", 32'(stall), 32'd1);
      tick();
      chk("raw_stall_b", 32'(stall), 32'd1);
      fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F800000; #1;
      chk("raw_fpu_ready", 32'(fpu_ready), 32'd1);
      chk("raw_stall_c", 32'(stall), 32'd1);
      tick();
      fpu_valid = 1'b0; #1;
      chk("raw_wb_en", 32'(float_wb_en), 32'd1);
      chk("raw_wb_addr", 32'(float_wb_addr), 32'd5);
      chk("raw_wb_data", float_write_data, 32'h3F800000);
      chk("raw_stall_d", 32'(stall), 32'd1);
      tick();
      chk("raw_wb_en_off", 32'(float_wb_en), 32'd0);
      chk("raw_stall_free", 32'(stall), 32'd0);
      issue_valid = 1'b0;

      // contested arbitration: FPU, LD, FPU, LD
      for (int r = 10; r <= 14; r++) begin
         issue(5'(r), 5'd0, 5'd0);
         tick();
      end
      issue_valid = 1'b0;
      fpu_valid = 1'b1; fpu_rd = 5'd10; fpu_data = 32'hA000_0010;
      ld_valid  = 1'b1; ld_rd  = 5'd11; ld_data  = 32'hB000_0011;
      #1;
      chk("arb1_fpu_ready", 32'(fpu_ready), 32'd1);
      chk("arb1_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("arb1_wb_addr", 32'(float_wb_addr), 32'd10);
      chk("arb1_wb_data", float_write_data, 32'hA000_0010);
      fpu_rd = 5'd12; fpu_data = 32'hA000_0012; #1;
      chk("arb2_fpu_ready", 32'(fpu_ready), 32'd0);
      chk("arb2_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      chk("arb2_wb_addr", 32'(float_wb_addr), 32'd11);
      chk("arb2_wb_data", float_write_data, 32'hB000_0011);
      ld_rd = 5'd13; ld_data = 32'hB000_0013; #1;
      chk("arb3_fpu_ready", 32'(fpu_ready), 32'd1);
      chk("arb3_ld_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("arb3_wb_addr", 32'(float_wb_addr), 32'd12);
      fpu_rd = 5'd14; fpu_data = 32'hA000_0014; #1;
      chk("arb4_fpu_ready", 32'(fpu_ready), 32'd0);
      chk("arb4_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      chk("arb4_wb_addr", 32'(float_wb_addr), 32'd13);
      chk("arb4_wb_data", float_write_data, 32'hB000_0013);
      ld_valid = 1'b0; #1;
      chk("arb5_fpu_ready", 32'(fpu_ready), 32'd1);
      tick();
      chk("arb5_wb_addr", 32'(float_wb_addr), 32'd14);
      fpu_valid = 1'b0;
      tick();
      chk("arb_wb_idle", 32'(float_wb_en), 32'd0);
      chk("arb_no_err", 32'(wb_err), 32'd0);

      // load to x0: accepted, no write, no error
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF; #1;
      chk("x0_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0;
      chk("x0_wb_en", 32'(float_wb_en), 32'd0);
      chk("x0_err", 32'(wb_err), 32'd0);

      // completion to non-busy rd=9: written, sticky error
      fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'h1234_5678; #1;
      chk("err_fpu_ready", 32'(fpu_ready), 32'd1);
      tick();
      fpu_valid = 1'b0;
      chk("err_wb_en", 32'(float_wb_en), 32'd1);
      chk("err_wb_addr", 32'(float_wb_addr), 32'd9);
      chk("err_wb_data", float_write_data, 32'h1234_5678);
      chk("err_set", 32'(wb_err), 32'd1);
      tick(); tick();
      chk("err_sticky", 32'(wb_err), 32'd1);

      // set wins over clear on the same bit
      issue(5'd7, 5'd0, 5'd0); #1;
      chk("sw_issue_stall", 32'(stall), 32'd0);
      tick();
      issue_valid = 1'b0;
      fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h7777_0001;
      tick();
      fpu_valid = 1'b0;
      chk("sw_wb_first", 32'(float_wb_addr), 32'd7);
      tick();
      fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'h7777_0002;
      tick();
      fpu_valid = 1'b0;
      issue(5'd7, 5'd0, 5'd0); #1;
      chk("sw_wb_en", 32'(float_wb_en), 32'd1);
      chk("sw_wb_addr", 32'(float_wb_addr), 32'd7);
      chk("sw_issue_stall2", 32'(stall), 32'd0);
      tick();
      issue(5'd8, 5'd0, 5'd7); #1;
      chk("sw_rs2_stall", 32'(stall), 32'd1);
      issue_valid = 1'b0;

      // reset mid-operation
      tick();
      issue(5'd3, 5'd0, 5'd0);
      tick();
      issue_valid = 1'b0;
      fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3333_3333;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'd0; #1;
      chk("mr_fpu_first", 32'(fpu_ready), 32'd1);
      tick();
      #1;
      chk("mr_ptr_ld", 32'(ld_ready), 32'd1);
      chk("mr_ptr_fpu", 32'(fpu_ready), 32'd0);
      chk("mr_wb_en", 32'(float_wb_en), 32'd1);
      rst = 1'b1; issue(5'd4, 5'd3, 5'd0); #1;
      chk("mr_wb_en_rst", 32'(float_wb_en), 32'd0);
      chk("mr_wb_addr_rst", 32'(float_wb_addr), 32'd0);
      chk("mr_wb_data_rst", float_write_data, 32'd0);
      chk("mr_err_rst", 32'(wb_err), 32'd0);
      chk("mr_stall_rst", 32'(stall), 32'd0);
      chk("mr_fpu_ready_rst", 32'(fpu_ready), 32'd1);
      chk("mr_ld_ready_rst", 32'(ld_ready), 32'd0);
      tick();
      rst = 1'b0; fpu_valid = 1'b0; ld_valid = 1'b0; #1;
      chk("mr_stall_after", 32'(stall), 32'd0);
      issue_valid = 1'b0;
      tick();
      chk("mr_hs_lost", 32'(float_wb_en), 32'd0);

      // randomized run against the model; DUT is now in its reset state
      foreach (mb[i]) mb[i] = 1'b0;
      mptr_ld = 1'b0; merr = 1'b0; mwen = 1'b0; mwaddr = 5'd0; mwdata = 32'd0;
      fhold = 1'b0; lhold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         issue(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
         issue_valid = ($urandom_range(1) == 1);
         if (!fhold) begin
            fpu_valid = ($urandom_range(2) == 0);
            fpu_rd = 5'($urandom_range(7)); fpu_data = $urandom;
         end
         if (!lhold) begin
            ld_valid = ($urandom_range(2) == 0);
            ld_rd = 5'($urandom_range(7)); ld_data = $urandom;
         end
         #1;
         e_stall = issue_valid && (mb[issue_rs1] || mb[issue_rs2] || mb[issue_rd]);
         if (fpu_valid && ld_valid) begin
            e_fg = !mptr_ld; e_lg = mptr_ld;
         end else begin
            e_fg = fpu_valid; e_lg = ld_valid;
         end
         chk("rnd_stall", 32'(stall), 32'(e_stall));
         chk("rnd_fpu_ready", 32'(fpu_ready), 32'(e_fg));
         chk("rnd_ld_ready", 32'(ld_ready), 32'(e_lg));
         xfer   = e_fg || e_lg;
         g_rd   = e_fg ? fpu_rd : ld_rd;
         g_data = e_fg ? fpu_data : ld_data;
         if (xfer && g_rd != 5'd0 && !mb[g_rd]) merr = 1'b1;
         if (mwen) mb[mwaddr] = 1'b0;
         if (issue_valid && !e_stall && issue_rd != 5'd0) mb[issue_rd] = 1'b1;
         mwen = xfer && g_rd != 5'd0; mwaddr = g_rd; mwdata = g_data;
         if (fpu_valid && ld_valid) mptr_ld = !mptr_ld;
         fhold = fpu_valid && !e_fg;
         lhold = ld_valid && !e_lg;
         tick();
         chk("rnd_wb_en", 32'(float_wb_en), 32'(mwen));
         if (mwen) begin
            chk("rnd_wb_addr", 32'(float_wb_addr), 32'(mwaddr));
            chk("rnd_wb_data", float_write_data, mwdata);
         end
         chk("rnd_err", 32'(wb_err), 32'(merr));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
